// File: rtl/conv4_window_feeder.sv
// conv4_window_feeder: streams a kernel then raster image into a 4-row line buffer and feeds 4x4 windows to the conv core
module conv4_window_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 4,
  parameter int IMG_W       = 28,
  parameter int IMG_H       = 28
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [DATA_WIDTH-1:0]             in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [KERNEL_SIZE*DATA_WIDTH-1:0] conv_data,
  output logic                              conv_kernel_load,
  output logic                              conv_valid_in,
  output logic                              conv_valid_out,
  output logic                              res_valid,
  output logic [$clog2(IMG_H)-1:0]          res_row,
  output logic [$clog2(IMG_W)-1:0]          res_col,
  output logic                              busy,
  output logic                              done
);
  localparam int OUT_W = IMG_W - 3;
  localparam int OUT_H = IMG_H - 3;
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);
  typedef enum logic [2:0] {IDLE, KLOAD, FILL, SWEEP, DRAIN} state_t;
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] lb [4][IMG_W];
  logic [DATA_WIDTH-1:0] krow [3];
  logic [3:0] kw;
  logic [XW-1:0] px, c, c0, c1, c2;
  logic [YW-1:0] r, r0, r1, r2;
  logic [1:0] py, k, slot;
  logic [2:0] need;
  logic acc, last_px, sweep_end, empty, v0, v1;
  assign acc = in_valid && in_ready;
  assign last_px = acc && state == FILL && px == XW'(IMG_W-1) && need == 3'd1;
  assign sweep_end = state == SWEEP && k == 2'd3 && c == XW'(OUT_W-1);
  assign empty = !(v0 || v1 || conv_valid_out || res_valid);
  assign slot = r[1:0] + k;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? KLOAD : IDLE;
      KLOAD:   state_n = (acc && kw == 4'd15) ? FILL : KLOAD;
      FILL:    state_n = last_px ? SWEEP : FILL;
      SWEEP:   state_n = sweep_end ? (r == YW'(OUT_H-1) ? DRAIN : FILL) : SWEEP;
      DRAIN:   state_n = empty ? IDLE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  // line buffer has no reset; its contents are always rewritten before use
  always_ff @(posedge clk)
    if (state == FILL && acc) lb[py][px] <= in_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      conv_data <= '0;
      conv_valid_in <= 1'b0;
      conv_kernel_load <= 1'b0;
      conv_valid_out <= 1'b0;
      res_valid <= 1'b0;
      res_row <= '0;
      res_col <= '0;
      krow <= '{default: '0};
      kw <= '0;
      px <= '0;
      py <= '0;
      c <= '0;
      r <= '0;
      k <= '0;
      need <= 3'd4;
      v0 <= 1'b0;
      v1 <= 1'b0;
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
    end else begin
      state <= state_n;
      in_ready <= state_n == KLOAD || state_n == FILL;
      busy <= state_n != IDLE;
      done <= state == DRAIN && empty;
      conv_valid_in <= 1'b0;
      conv_kernel_load <= 1'b0;
      if (state == IDLE) begin
        kw <= '0;
        px <= '0;
        py <= '0;
        c <= '0;
        r <= '0;
        k <= '0;
        need <= 3'd4;
      end
      if (state == KLOAD && acc) begin
        kw <= kw + 4'd1;
        if (kw[1:0] != 2'd3) krow[kw[1:0]] <= in_data;
        else begin
          conv_data <= {in_data, krow[2], krow[1], krow[0]};
          conv_valid_in <= 1'b1;
          conv_kernel_load <= 1'b1;
        end
      end
      if (state == FILL && acc) begin
        px <= px == XW'(IMG_W-1) ? '0 : px + XW'(1);
        if (px == XW'(IMG_W-1)) begin
          py <= py + 2'd1;
          need <= need - 3'd1;
        end
      end
      if (state == SWEEP) begin
        for (int j = 0; j < KERNEL_SIZE; j++)
          conv_data[j*DATA_WIDTH +: DATA_WIDTH] <= lb[slot][c + XW'(j)];
        conv_valid_in <= 1'b1;
        k <= k + 2'd1;
        if (k == 2'd3) c <= c == XW'(OUT_W-1) ? '0 : c + XW'(1);
        if (sweep_end && r != YW'(OUT_H-1)) begin
          r <= r + YW'(1);
          need <= 3'd1;
        end
      end
      // result tag pipeline runs freely, so it keeps draining after the FSM moves on
      v0 <= state == SWEEP && k == 2'd3;
      r0 <= r;
      c0 <= c;
      v1 <= v0;
      r1 <= r0;
      c1 <= c0;
      conv_valid_out <= v1;
      r2 <= r1;
      c2 <= c1;
      res_valid <= conv_valid_out;
      res_row <= r2;
      res_col <= c2;
    end
  end
endmodule

// File: tb/tb_conv4_window_feeder.sv
// tb_conv4_window_feeder: scoreboard bench for the window feeder on a 6x5 image
module tb_conv4_window_feeder;
  localparam int DW = 16;
  localparam int W = 6;
  localparam int H = 5;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, conv_kernel_load, conv_valid_in, conv_valid_out, res_valid, busy, done;
  logic [4*DW-1:0] conv_data;
  logic [2:0] res_row, res_col;
  typedef struct {logic [63:0] d; logic kl;} row_t;
  row_t exp_rows[$];
  logic [5:0] exp_res[$];
  int t3a[$], t3b[$];
  int vectors = 0, errors = 0, cyc = 0, wk = 0, run = 0, nres = 0, ndone = 0;
  bit mon_en = 1'b0, tog = 1'b0;
  row_t e;
  logic [5:0] er;
  int t;

  always #5 clk = ~clk;

  conv4_window_feeder #(.DATA_WIDTH(DW), .KERNEL_SIZE(4), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .conv_data(conv_data), .conv_kernel_load(conv_kernel_load),
    .conv_valid_in(conv_valid_in), .conv_valid_out(conv_valid_out), .res_valid(res_valid),
    .res_row(res_row), .res_col(res_col), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_job();
    logic [63:0] d;
    for (int kr = 0; kr < 4; kr++) begin
      for (int j = 0; j < 4; j++) d[j*16 +: 16] = 16'(4*kr + j + 1);
      exp_rows.push_back('{d, 1'b1});
    end
    for (int r = 0; r < H-3; r++)
      for (int c = 0; c < W-3; c++) begin
        for (int k = 0; k < 4; k++) begin
          for (int j = 0; j < 4; j++) d[j*16 +: 16] = 16'(10*(r+k) + c + j);
          exp_rows.push_back('{d, 1'b0});
        end
        exp_res.push_back({3'(r), 3'(c)});
      end
  endtask

  task automatic send(input logic [15:0] w, input bit stall);
    bit acc = 1'b0;
    int g = 0;
    while (!acc && g < 2000) begin
      @(negedge clk);
      in_data = w;
      if (stall) tog = !tog;
      in_valid = stall ? tog : 1'b1;
      acc = in_valid && in_ready;
      g++;
    end
    chk("accept", 64'(acc), 64'd1);
    @(posedge clk);
  endtask

  task automatic feed(input bit stall);
    for (int i = 1; i <= 16; i++) send(16'(i), 1'b0);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) send(16'(10*y + x), stall);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_sweep();
    int g = 0;
    while (!(conv_valid_in && !conv_kernel_load) && g < 2000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic begin_job();
    nres = 0;
    ndone = 0;
    wk = 0;
    run = 0;
    expect_job();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_job(input bit stall, input bit extra);
    int g = 0;
    begin_job();
    fork
      feed(stall);
      if (extra) begin
        wait_sweep();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    join
    while (ndone == 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    repeat (6) @(negedge clk);
    chk("results", 64'(nres), 64'd6);
    chk("dones", 64'(ndone), 64'd1);
    chk("rows_left", 64'(exp_rows.size()), 64'd0);
    chk("res_left", 64'(exp_res.size()), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
  endtask

  always @(negedge clk) if (mon_en) begin
    cyc++;
    if (conv_valid_in) begin
      if (exp_rows.size() == 0) chk("row_extra", 64'(exp_rows.size()), 64'd1);
      else begin
        e = exp_rows.pop_front();
        chk("conv_data", conv_data, e.d);
        chk("kload", 64'(conv_kernel_load), 64'(e.kl));
        if (!e.kl) begin
          wk++;
          if (wk % 4 == 0) begin
            t3a.push_back(cyc);
            t3b.push_back(cyc);
          end
        end
      end
    end
    if (conv_valid_in && !conv_kernel_load) run++;
    else if (run > 0) begin
      chk("run_len", 64'(run), 64'd12);
      run = 0;
    end
    if (conv_valid_out) begin
      t = t3a.size() ? t3a.pop_front() : -100;
      chk("cvo_lat", 64'(cyc - t), 64'd2);
    end
    if (res_valid) begin
      nres++;
      t = t3b.size() ? t3b.pop_front() : -100;
      chk("res_lat", 64'(cyc - t), 64'd3);
      er = exp_res.size() ? exp_res.pop_front() : 6'h3f;
      chk("res_coord", {58'd0, res_row, res_col}, 64'(er));
    end
    if (done) ndone++;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctl", 64'({in_ready, conv_valid_in, conv_kernel_load, conv_valid_out, res_valid, busy, done}), 64'd0);
    chk("rst_data", conv_data, 64'd0);
    chk("rst_tag", 64'({res_row, res_col}), 64'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", 64'(in_ready), 64'd0);
    mon_en = 1'b1;
    run_job(1'b0, 1'b0);
    run_job(1'b1, 1'b0);
    run_job(1'b0, 1'b1);
    begin_job();
    fork
      feed(1'b0);
      begin
        wait_sweep();
        repeat (2) @(negedge clk);
        #2;
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_ctl", 64'({in_ready, conv_valid_in, conv_kernel_load, conv_valid_out, res_valid, busy, done}), 64'd0);
        chk("abort_data", conv_data, 64'd0);
        chk("abort_tag", 64'({res_row, res_col}), 64'd0);
      end
    join_any
    disable fork;
    in_valid = 1'b0;
    exp_rows.delete();
    exp_res.delete();
    t3a.delete();
    t3b.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_ready", 64'(in_ready), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    mon_en = 1'b1;
    run_job(1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
